instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 Parameter: PC_STEP, 1, PC increment per fetched word; instruction memory is word-addressed.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  synchronous reset, active-low.
REQ-005 Port: en  input  1  run enable; 0 means no new fetch is started.
REQ-006 Port: branch_taken  input  1  redirect request from execute.
REQ-007 Port: branch_target  input  8  redirect PC.
REQ-008 Port: imem_req  output  1  fetch request to instruction memory.
REQ-009 Port: imem_addr  output  8  fetch address; equals pc while imem_req=1.
REQ-010 Port: imem_ack  input  1  memory response strobe; qualifies imem_rdata for one cycle.
REQ-011 Port: imem_rdata  input  32  fetched instruction word.
REQ-012 Port: instr_valid  output  1  instruction register holds a valid word for decode.
REQ-013 Port: instr_ready  input  1  decode and immediate stage accept the word.
REQ-014 Port: instruction  output  32  registered instruction word that drives the decode and immediate-generation stage.
REQ-015 Port: pc_out  output  8  address of the word in instruction.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, HOLD and FLUSH.
REQ-017 In IDLE, imem_req=0 and instr_valid=0; the FSM SHALL enter FETCH on the next edge when en=1.
REQ-018 In FETCH, imem_req=1 and imem_addr=pc, held until imem_ack=1, regardless of en.
REQ-019 On FETCH with imem_ack=1, the block SHALL, at that edge:
  - capture imem_rdata into instruction and pc into pc_out;
  - set pc <= pc+PC_STEP, wrapping modulo 256 (8'hFF+1 -> 8'h00);
  - set instr_valid <= 1 and enter HOLD.
  Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-020 In HOLD, instruction and pc_out SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-021 In HOLD with instr_ready=1:
  - instr_valid <= 0;
  - next state FETCH if en=1, else IDLE;
  - no back-to-back overlap, so the peak rate is one word per 2 cycles plus memory wait.
REQ-022 branch_taken=1 in any state SHALL, at that edge:
  - set pc <= branch_target and instr_valid <= 0;
  - discard any simultaneous imem_ack/imem_rdata;
  - enter FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle with imem_req=0, then go to FETCH if en=1, else IDLE.
REQ-024 branch_taken SHALL take priority over imem_ack, instr_ready and en in the same cycle.
REQ-025 instr_ready while instr_valid=0 SHALL be ignored.
REQ-026 imem_ack outside FETCH SHALL be ignored.
REQ-027 en falling during FETCH SHALL NOT abort the outstanding request; the word is delivered through HOLD, then the FSM goes to IDLE.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set:
  - pc=RESET_PC and state=IDLE;
  - imem_req=0, instr_valid=0;
  - instruction=32'h0, pc_out=8'h00.
  Reset overrides branch_taken and imem_ack.
REQ-029 Reset asserted mid-fetch SHALL drop the request in the same cycle; a late imem_ack after release SHALL be ignored unless the FSM is in FETCH.
REQ-030 imem_addr SHALL equal RESET_PC during and after reset until the first redirect or increment.

Structure
REQ-031 The shared package cpu_pkg SHALL hold:
  - the fetch-state enumeration;
  - ADDR_W=8 and INSTR_W=32;
  - the RESET_PC default.
REQ-032 The PC register, increment and redirect mux SHALL be the sub-module pc_counter; the FSM, instruction register and handshake stay in instr_fetch.

Verification
REQ-033 Reset, en=1, ack one cycle after each req with rdata=32'hA1B2C3D4, ready=1 -> imem_addr 00, then 01; instr_valid first high 1 cycle after ack; pc_out=00.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instruction and pc_out constant, imem_req=0; ready=1 -> next fetch at pc+1.
REQ-035 branch_taken=1, target=8'h40, in the same cycle as imem_ack -> word discarded, instr_valid=0, one FLUSH cycle with req=0, next imem_addr=8'h40.
REQ-036 pc=8'hFF fetch completes -> next imem_addr=8'h00.
REQ-037 en dropped mid-FETCH with ack delayed 3 cycles -> word delivered, then IDLE with imem_req=0.
REQ-038 rst_n=0 during FETCH with a pending ack -> all outputs at reset values next cycle; first request after release is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and widths.
package cpu_pkg;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory and decode handshake bundle for the fetch stage.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc_out,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc_out,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_counter.sv
// Program counter: reset load, branch redirect, and modulo-256 increment.
module pc_counter
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = 8'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);
  logic [ADDR_W-1:0] r_pc;

  // Redirect wins over increment; the add wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_target;
    else if (i_inc)  r_pc <= r_pc + PC_STEP;
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: request/ack handshake to instruction memory, one-word hold register toward decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = 8'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  instr_fetch_if.master     bus
);
  fetch_state_t       r_state;
  logic               r_req;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_inc;

  assign w_inc = (r_state == FETCH) && bus.imem_ack && !branch_taken;

  pc_counter #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (branch_taken),
    .i_target (branch_target),
    .i_inc    (w_inc),
    .o_pc     (w_pc)
  );

  // Reset beats branch, branch beats every per-state action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else if (branch_taken) begin
      r_state <= FLUSH;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FLUSH: begin
          if (en) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            r_instr  <= bus.imem_rdata;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
            r_req    <= 1'b0;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            r_valid <= 1'b0;
            if (en) begin
              r_state <= FETCH;
              r_req   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = w_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instruction = r_instr;
  assign bus.pc_out      = r_pc_out;
endmodule
